// File: rtl/atom_pkg.sv
// Shared types and destination-select encodings used by the stateless atom
// and the PHV writeback stage.
package atom_pkg;

  localparam int COUNT_WIDTH_DEF = 32;

  typedef logic signed [31:0] int32_t;
  typedef logic signed [1:0]  int2_t;

  typedef enum logic [1:0] {
    DST_PKT1 = 2'd0,
    DST_PKT2 = 2'd1,
    DST_PKT3 = 2'd2,
    DST_NONE = 2'd3
  } dst_sel_e;

endpackage

// File: rtl/phv_fifo2.sv
// Two-entry valid/ready FIFO; ready and valid decode only from registered
// occupancy, and the output bus reads as zero while empty.
module phv_fifo2 #(
  parameter int W     = 97,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_ready = (r_count < FULL);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  // Reset wins over any handshake in the same cycle, dropping buffered entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/phv_writeback.sv
// Merges the stateless-atom result into the selected packet field, buffers the
// packet, and counts delivered and written-back packets.
module phv_writeback
  import atom_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COUNT_WIDTH-1:0] in_pkt_1,
  input  logic [COUNT_WIDTH-1:0] in_pkt_2,
  input  logic [COUNT_WIDTH-1:0] in_pkt_3,
  input  logic [COUNT_WIDTH-1:0] in_result,
  input  logic [1:0]             dst_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] out_pkt_1,
  output logic [COUNT_WIDTH-1:0] out_pkt_2,
  output logic [COUNT_WIDTH-1:0] out_pkt_3,
  output logic [COUNT_WIDTH-1:0] pkt_count,
  output logic [COUNT_WIDTH-1:0] wb_count
);

  localparam int ENTRY_W = 3 * COUNT_WIDTH + 1;

  function automatic logic [ENTRY_W-1:0] merge_entry(
    input logic [COUNT_WIDTH-1:0] f1,
    input logic [COUNT_WIDTH-1:0] f2,
    input logic [COUNT_WIDTH-1:0] f3,
    input logic [COUNT_WIDTH-1:0] res,
    input logic [1:0]             sel
  );
    logic [COUNT_WIDTH-1:0] m1, m2, m3;
    logic                   wr;
    m1 = f1;
    m2 = f2;
    m3 = f3;
    wr = 1'b1;
    case (dst_sel_e'(sel))
      DST_PKT1: m1 = res;
      DST_PKT2: m2 = res;
      DST_PKT3: m3 = res;
      default:  wr = 1'b0;
    endcase
    return {wr, m3, m2, m1};
  endfunction

  logic [ENTRY_W-1:0]     w_entry_p0;
  logic [ENTRY_W-1:0]     w_head_p1;
  logic                   w_pop;
  logic [COUNT_WIDTH-1:0] r_pkt_count;
  logic [COUNT_WIDTH-1:0] r_wb_count;

  // Stage p0: merge happens at the push, so dst_sel is captured with the entry.
  assign w_entry_p0 = merge_entry(in_pkt_1, in_pkt_2, in_pkt_3, in_result, dst_sel);

  phv_fifo2 #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_entry_p0),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_head_p1)
  );

  // Stage p1: head entry drives outputs; counters advance on each pop.
  assign out_pkt_1 = w_head_p1[COUNT_WIDTH-1:0];
  assign out_pkt_2 = w_head_p1[2*COUNT_WIDTH-1:COUNT_WIDTH];
  assign out_pkt_3 = w_head_p1[3*COUNT_WIDTH-1:2*COUNT_WIDTH];
  assign w_pop     = out_valid & out_ready;
  assign pkt_count = r_pkt_count;
  assign wb_count  = r_wb_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
      r_wb_count  <= '0;
    end else if (w_pop) begin
      r_pkt_count <= r_pkt_count + COUNT_WIDTH'(1);
      if (w_head_p1[ENTRY_W-1]) r_wb_count <= r_wb_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_phv_writeback.sv
// Directed bench for phv_writeback: merge, ordering, full/empty, reset, wrap.
module tb_phv_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pkt_1, in_pkt_2, in_pkt_3, in_result;
  logic [1:0]  dst_sel;
  logic [31:0] out_pkt_1, out_pkt_2, out_pkt_3, pkt_count, wb_count;

  logic       s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [3:0] s_in_pkt_1, s_in_pkt_2, s_in_pkt_3, s_in_result;
  logic [1:0] s_dst_sel;
  logic [3:0] s_out_pkt_1, s_out_pkt_2, s_out_pkt_3, s_pkt_count, s_wb_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  phv_writeback #(.COUNT_WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pkt_1(in_pkt_1), .in_pkt_2(in_pkt_2), .in_pkt_3(in_pkt_3),
    .in_result(in_result), .dst_sel(dst_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_pkt_1(out_pkt_1), .out_pkt_2(out_pkt_2),
    .out_pkt_3(out_pkt_3), .pkt_count(pkt_count), .wb_count(wb_count)
  );

  phv_writeback #(.COUNT_WIDTH(4), .DEPTH(2)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pkt_1(s_in_pkt_1), .in_pkt_2(s_in_pkt_2), .in_pkt_3(s_in_pkt_3),
    .in_result(s_in_result), .dst_sel(s_dst_sel), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_pkt_1(s_out_pkt_1), .out_pkt_2(s_out_pkt_2),
    .out_pkt_3(s_out_pkt_3), .pkt_count(s_pkt_count), .wb_count(s_wb_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p1, p2, p3, res, input logic [1:0] sel);
    in_valid  = v;
    in_pkt_1  = p1;
    in_pkt_2  = p2;
    in_pkt_3  = p3;
    in_result = res;
    dst_sel   = sel;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e1, e2, e3);
    chk(tag, {out_pkt_3, out_pkt_2, out_pkt_1}, {e3, e2, e1});
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_in_pkt_1 = 4'h1; s_in_pkt_2 = 4'h2; s_in_pkt_3 = 4'h3; s_in_result = 4'h5; s_dst_sel = 2'd0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk_out("rst_out_pkt", 32'h0, 32'h0, 32'h0);
    chk("rst_counts", {pkt_count, wb_count}, 64'h0);
    rst_n = 1'b1; s_rst_n = 1'b1;
    tick();

    // Basic merge into pkt_2
    drive(1'b1, 32'h1, 32'h2, 32'h3, 32'hAA, 2'd1); out_ready = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    chk("m1_valid", out_valid, 1'b1);
    chk_out("m1_out", 32'h1, 32'hAA, 32'h3);
    tick();
    chk("m1_pkt_count", pkt_count, 32'd1);
    chk("m1_wb_count", wb_count, 32'd1);
    chk("m1_empty_valid", out_valid, 1'b0);
    chk_out("m1_empty_zero", 32'h0, 32'h0, 32'h0);

    // Discard result
    drive(1'b1, 32'h4, 32'h5, 32'h6, 32'hFF, 2'd3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    chk_out("none_out", 32'h4, 32'h5, 32'h6);
    tick();
    chk("none_counts", {pkt_count, wb_count}, {32'd2, 32'd1});

    // Merge into pkt_1, dst_sel changes afterwards, output held while stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h7, 32'h8, 32'h9, 32'h11, 2'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2);
    chk_out("p1_out", 32'h11, 32'h8, 32'h9);
    tick();
    chk_out("p1_stall_hold", 32'h11, 32'h8, 32'h9);
    chk("p1_stall_count", pkt_count, 32'd2);
    out_ready = 1'b1;
    tick();
    chk("p1_counts", {pkt_count, wb_count}, {32'd3, 32'd2});

    // Back-to-back A, B, C with downstream stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h11, 32'h12, 32'hA0, 2'd2);
    tick();
    chk("abc_ready1", in_ready, 1'b1);
    drive(1'b1, 32'h20, 32'h21, 32'h22, 32'hB0, 2'd0);
    tick();
    chk("abc_ready_full", in_ready, 1'b0);
    chk_out("abc_head_a", 32'h10, 32'h11, 32'hA0);
    drive(1'b1, 32'h30, 32'h31, 32'h32, 32'hC0, 2'd1);
    tick();
    chk("abc_c_held", in_ready, 1'b0);
    chk_out("abc_head_a2", 32'h10, 32'h11, 32'hA0);
    out_ready = 1'b1;
    tick();
    chk("abc_pop_a_ready", in_ready, 1'b1);
    chk_out("abc_head_b", 32'hB0, 32'h21, 32'h22);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    chk("abc_c_valid", out_valid, 1'b1);
    chk_out("abc_head_c", 32'h30, 32'hC0, 32'h32);
    tick();
    chk("abc_drained", out_valid, 1'b0);
    chk("abc_counts", {pkt_count, wb_count}, {32'd6, 32'd5});

    // Push and pop together at occupancy 1
    out_ready = 1'b0;
    drive(1'b1, 32'h40, 32'h41, 32'h42, 32'hDD, 2'd3);
    tick();
    drive(1'b1, 32'h50, 32'h51, 32'h52, 32'hEE, 2'd0); out_ready = 1'b1;
    tick();
    drive(1'b0, 32'hDEAD, 32'hBEEF, 32'h1234, 32'h5678, 2'd1);
    chk("pp_valid", out_valid, 1'b1);
    chk("pp_ready", in_ready, 1'b1);
    chk_out("pp_head_e", 32'hEE, 32'h51, 32'h52);
    chk("pp_counts1", {pkt_count, wb_count}, {32'd7, 32'd5});
    tick();
    chk("pp_empty", out_valid, 1'b0);
    tick();
    chk("pp_counts2", {pkt_count, wb_count}, {32'd8, 32'd6});

    // Reset with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 32'h60, 32'h61, 32'h62, 32'h66, 2'd0);
    tick();
    drive(1'b1, 32'h70, 32'h71, 32'h72, 32'h77, 2'd1);
    tick();
    chk("mr_full", {out_valid, in_ready}, 2'b10);
    rst_n = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    chk("mr_flags", {out_valid, in_ready}, 2'b01);
    chk("mr_counts", {pkt_count, wb_count}, 64'h0);
    chk_out("mr_out_zero", 32'h0, 32'h0, 32'h0);
    tick();
    chk("mr_no_emit", {out_valid, pkt_count}, 33'h0);

    // Counter wrap on the 4-bit instance
    s_in_valid = 1'b1; s_out_ready = 1'b1;
    tick();
    chk("w_first_out", {s_out_valid, s_out_pkt_3, s_out_pkt_2, s_out_pkt_1}, 13'h1325);
    for (int i = 0; i < 14; i++) tick();
    chk("w_ready", s_in_ready, 1'b1);
    s_in_valid = 1'b0;
    tick();
    chk("w_count_max", {s_pkt_count, s_wb_count}, 8'hFF);
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    tick();
    chk("w_count_wrap", {s_pkt_count, s_wb_count}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/phv_writeback.md
PHV_WRITEBACK -- requirements
Module: phv_writeback

Interface
REQ-001 Parameter COUNT_WIDTH, default 32, SHALL set the width of every packet field, result and counter.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of buffered packet entries; only 2 is supported.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  upstream holds a valid packet plus atom result.
REQ-006 in_ready  output  1  block can accept a packet this cycle.
REQ-007 in_pkt_1, in_pkt_2, in_pkt_3  input  COUNT_WIDTH each  packet header fields as presented to the stateless atom.
REQ-008 in_result  input  COUNT_WIDTH  stateless atom o_write value for this packet.
REQ-009 dst_sel  input  2  destination field: 0 = pkt_1, 1 = pkt_2, 2 = pkt_3, 3 = discard result.
REQ-010 out_valid  output  1  buffered packet available downstream.
REQ-011 out_ready  input  1  downstream accepts the packet this cycle.
REQ-012 out_pkt_1, out_pkt_2, out_pkt_3  output  COUNT_WIDTH each  packet fields after writeback.
REQ-013 pkt_count  output  COUNT_WIDTH  number of packets delivered downstream.
REQ-014 wb_count  output  COUNT_WIDTH  number of delivered packets whose dst_sel was 0-2.

Function
REQ-015 A push SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-016 On push, the stored entry SHALL hold the in_pkt fields, with the field chosen by dst_sel replaced by in_result; dst_sel = 3 SHALL store all fields unchanged.
REQ-017 The merge SHALL use dst_sel sampled in the push cycle; later changes to dst_sel SHALL NOT affect stored entries.
REQ-018 Each entry SHALL carry one written flag, set when dst_sel != 3.
REQ-019 Latency: a push into an empty buffer SHALL raise out_valid on the next cycle with the merged fields.
REQ-020 Entries SHALL leave in FIFO order; out_pkt_* SHALL show the head entry and stay stable while out_valid = 1 and out_ready = 0.
REQ-021 in_ready SHALL equal (occupancy < DEPTH), decoded from registered state only, with no combinational path from out_ready.
REQ-022 Full case: with occupancy = 2, in_ready = 0; a same-cycle pop SHALL give occupancy 1 next cycle and SHALL accept no push.
REQ-023 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new entry behind the popped one.
REQ-024 Empty case: out_valid = 0 and out_pkt_* SHALL be held at 0; out_ready SHALL be ignored.
REQ-025 In the pop cycle, pkt_count SHALL increment by 1, and wb_count SHALL also increment when the head written flag = 1.
REQ-026 Both counters SHALL wrap from 2^COUNT_WIDTH-1 to 0 without saturation or a flag.
REQ-027 in_* values SHALL be ignored whenever no push occurs.

Reset
REQ-028 While rst_n = 0 at a clock edge: occupancy = 0, pointers = 0, stored entries = 0, pkt_count = 0, wb_count = 0.
REQ-029 Outputs during and immediately after reset: out_valid = 0, out_pkt_* = 0, in_ready = 1.
REQ-030 Reset asserted mid-operation SHALL discard buffered packets without delivering them; no push or pop SHALL occur in that cycle.

Structure
REQ-031 Types int32_t and int2_t, the dst_sel encodings (DST_PKT1/2/3, DST_NONE) and the default COUNT_WIDTH SHALL live in shared package atom_pkg, which the stateless atom also uses.
REQ-032 Buffering SHALL be one sub-module, phv_fifo2 (2-entry FIFO with valid/ready, width 3*COUNT_WIDTH+1); merge logic and counters SHALL stay in phv_writeback.

Verification
REQ-033 Push pkt = (1,2,3), result = 0xAA, dst_sel = 1, out_ready = 1 -> next cycle out = (1,0xAA,3), pkt_count = 1, wb_count = 1.
REQ-034 Push with dst_sel = 3 and result = 0xFF -> out = in_pkt unchanged; pkt_count increments, wb_count does not.
REQ-035 out_ready = 0, three back-to-back pushes A, B, C -> A and B accepted, in_ready = 0 from cycle 2, C held off; then out_ready = 1 -> A, B, C delivered in order.
REQ-036 Occupancy 1, push and pop in the same cycle -> occupancy stays 1, correct order, no loss or duplicate.
REQ-037 Preload pkt_count = 0xFFFFFFFF (force or long run), pop one packet -> pkt_count = 0.
REQ-038 Two entries buffered, rst_n = 0 for one cycle -> out_valid = 0, in_ready = 1, counters = 0, no packet emitted.
